// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell shared by the serial datapath.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder, LSB first through one FA cell.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  // Elaboration stops on an out-of-range WIDTH.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    illegal_width_parameter u_bad ();
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry_r;
  logic             sub_in;
  logic             sub_r;
  logic             fa_b;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_r <= 1'b0;
    end else if (state == IDLE && start) begin
      sub_r <= sub;
    end
  end
`else
  assign sub_in = 1'b0;
  assign sub_r  = 1'b0;
`endif

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign fa_b     = b_sr[0] ^ sub_r;

  serial_adder_fa u_fa (
    .a    (a_sr[0]),
    .b    (fa_b),
    .cin  (carry_r),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // Sum enters at the MSB so after WIDTH shifts bit 0 sits at result[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      cnt       <= '0;
      carry_r   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= op_a;
            b_sr    <= op_b;
            cnt     <= '0;
            carry_r <= sub_in;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          result  <= {fa_sum, result[WIDTH-1:1]};
          carry_r <= fa_cout;
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            carry_out <= fa_cout;
            overflow  <= carry_r ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and check latency, flags and the return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_r, input logic exp_c,
                        input logic exp_v);
    int n;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom_range(0, 255);
    op_b  = $urandom_range(0, 255);
    sub   = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (n < 20 && !done) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, 32'd8);
    check({tag, "_result"}, {24'd0, result}, {24'd0, exp_r});
    check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_v});
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_held"}, {24'd0, result}, {24'd0, exp_r});
  endtask

  initial begin
    int done_cnt;
    logic [7:0] exp_q[$];
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    sub   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, carry_out, overflow, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_outs", {busy, done, carry_out, overflow, result}, 32'd0);

    run_op("add_35_1a", 8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
`endif

    // Abort after three RUN edges.
    @(negedge clk);
    op_a  = 8'h55;
    op_b  = 8'h33;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {busy, done, carry_out, overflow, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_idle_outs", {busy, done, carry_out, overflow, result}, 32'd0);
    run_op("add_02_03", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);

    // start held high: accepts at edges 0, 10, 20 (DONE ignores start).
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h53);
    exp_q.push_back(8'hA3);
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      op_a  = 8'(j * 3 + 1);
      op_b  = 8'(j * 5 + 2);
      start = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("b2b_busy_%0d", j), {31'd0, busy}, {31'd0, (j % 10) != 9});
      check($sformatf("b2b_done_%0d", j), {31'd0, done}, {31'd0, (j % 10) == 8});
      if ((j % 10) == 8 && exp_q.size() > 0) begin
        check($sformatf("b2b_result_%0d", j), {24'd0, result}, {24'd0, exp_q.pop_front()});
        if (j == 28) check("b2b_ovf_last", {30'd0, carry_out, overflow}, 32'd1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_end_idle", {30'd0, busy, done}, 32'd0);
    check("b2b_all_seen", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
